// File: rtl/mac_share_arbiter.sv
// -----------------------------------------------------------------------------
// mac_share_arbiter
//
// Shares one pipelined MAC datapath (y = a*b + c*d + e) among N_REQ
// requesters. Requests are granted round-robin into a single registered issue
// stage that feeds the MAC. Every accepted operation pushes its requester tag
// into an in-order FIFO. Because the MAC returns results in order, the FIFO
// head always names the owner of the result currently presented by the MAC.
//
// Ports
//   clk            clock, all logic on posedge
//   rst            asynchronous active-low reset, released synchronously
//   req_valid      per-requester operation valid
//   req_ready      per-requester accept, at most one bit set
//   req_a..req_e   flattened 16-bit signed operands, requester i at [16i+15:16i]
//   mac_in_valid   issue register valid towards the MAC
//   mac_in_ready   MAC takes the issue register
//   mac_a..mac_e   issue register operands
//   mac_out_valid  MAC result valid
//   mac_out_ready  MAC result consumed
//   mac_y          32-bit MAC result
//   rsp_valid      one-hot result valid to the owning requester
//   rsp_ready      per-requester result accept
//   rsp_y          result, combinational copy of mac_y
//   outstanding    accepted-but-unreturned operations (tag FIFO occupancy)
//   proto_err      sticky flag: MAC result seen while no operation was pending
// -----------------------------------------------------------------------------
module mac_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int DEPTH = 8,
  parameter int TAG_W = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [16*N_REQ-1:0]      req_a,
  input  logic [16*N_REQ-1:0]      req_b,
  input  logic [16*N_REQ-1:0]      req_c,
  input  logic [16*N_REQ-1:0]      req_d,
  input  logic [16*N_REQ-1:0]      req_e,
  output logic                     mac_in_valid,
  input  logic                     mac_in_ready,
  output logic [15:0]              mac_a,
  output logic [15:0]              mac_b,
  output logic [15:0]              mac_c,
  output logic [15:0]              mac_d,
  output logic [15:0]              mac_e,
  input  logic                     mac_out_valid,
  output logic                     mac_out_ready,
  input  logic [31:0]              mac_y,
  output logic [N_REQ-1:0]         rsp_valid,
  input  logic [N_REQ-1:0]         rsp_ready,
  output logic [31:0]              rsp_y,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic                     proto_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [TAG_W-1:0] r_rr_ptr;
  logic             r_issue_valid;
  logic [15:0]      r_a;
  logic [15:0]      r_b;
  logic [15:0]      r_c;
  logic [15:0]      r_d;
  logic [15:0]      r_e;
  logic [TAG_W-1:0] r_tag_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_proto_err;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  logic             w_fifo_empty;
  logic             w_fifo_full;
  logic             w_can_issue;
  logic             w_any_req;
  logic             w_accept;
  logic             w_pop;
  logic [TAG_W-1:0] w_winner;
  logic [TAG_W-1:0] w_head;
  logic [15:0]      w_sel_a;
  logic [15:0]      w_sel_b;
  logic [15:0]      w_sel_c;
  logic [15:0]      w_sel_d;
  logic [15:0]      w_sel_e;
  int               w_idx;
  int               w_win_base;

  assign w_fifo_empty = (r_count == '0);
  assign w_fifo_full  = (r_count == CNT_W'(DEPTH));

  // The occupancy test uses the count before any same-cycle pop, so a full
  // FIFO blocks new accepts even while a result is draining. This keeps the
  // accept path free of any dependency on the MAC output handshake.
  assign w_can_issue  = (!r_issue_valid || mac_in_ready) && !w_fifo_full;

  // ---------------------------------------------------------------------------
  // Round-robin winner: first valid requester after the last one granted
  // ---------------------------------------------------------------------------
  always_comb begin
    w_any_req = 1'b0;
    w_winner  = r_rr_ptr;
    w_idx     = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = (int'(r_rr_ptr) + k) % N_REQ;
      if (!w_any_req && req_valid[w_idx]) begin
        w_any_req = 1'b1;
        w_winner  = TAG_W'(w_idx);
      end
    end
  end

  // Only the winner sees ready, and only when the issue stage can take it.
  always_comb begin
    req_ready = '0;
    if (w_any_req && w_can_issue) begin
      req_ready[w_winner] = 1'b1;
    end
  end

  assign w_accept = w_any_req && w_can_issue;

  // ---------------------------------------------------------------------------
  // Operand select for the winner
  // ---------------------------------------------------------------------------
  always_comb begin
    w_win_base = 16 * int'(w_winner);
    w_sel_a    = req_a[w_win_base +: 16];
    w_sel_b    = req_b[w_win_base +: 16];
    w_sel_c    = req_c[w_win_base +: 16];
    w_sel_d    = req_d[w_win_base +: 16];
    w_sel_e    = req_e[w_win_base +: 16];
  end

  // ---------------------------------------------------------------------------
  // Issue register and round-robin pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_issue_valid <= 1'b0;
      r_a           <= '0;
      r_b           <= '0;
      r_c           <= '0;
      r_d           <= '0;
      r_e           <= '0;
      r_rr_ptr      <= TAG_W'(N_REQ - 1);
    end else begin
      if (w_accept) begin
        // Loading while the MAC consumes the previous entry gives 1 op/cycle.
        r_issue_valid <= 1'b1;
        r_a           <= w_sel_a;
        r_b           <= w_sel_b;
        r_c           <= w_sel_c;
        r_d           <= w_sel_d;
        r_e           <= w_sel_e;
        r_rr_ptr      <= w_winner;
      end else if (mac_in_ready) begin
        r_issue_valid <= 1'b0;
      end
    end
  end

  assign mac_in_valid = r_issue_valid;
  assign mac_a        = r_a;
  assign mac_b        = r_b;
  assign mac_c        = r_c;
  assign mac_d        = r_d;
  assign mac_e        = r_e;

  // ---------------------------------------------------------------------------
  // Response routing from the FIFO head
  // ---------------------------------------------------------------------------
  assign w_head        = r_tag_mem[r_rd_ptr];
  assign mac_out_ready = !w_fifo_empty && rsp_ready[w_head];
  assign w_pop         = mac_out_valid && mac_out_ready;
  assign rsp_y         = mac_y;

  always_comb begin
    rsp_valid = '0;
    if (mac_out_valid && !w_fifo_empty) begin
      rsp_valid[w_head] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Tag FIFO: pointers wrap naturally because DEPTH is a power of two; the
  // separate count distinguishes full from empty.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_tag_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept) begin
        r_tag_mem[r_wr_ptr] <= w_winner;
        r_wr_ptr            <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign outstanding = r_count;

  // ---------------------------------------------------------------------------
  // Sticky protocol error: a result arrived with nothing pending.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_proto_err <= 1'b0;
    end else if (mac_out_valid && w_fifo_empty) begin
      r_proto_err <= 1'b1;
    end
  end

  assign proto_err = r_proto_err;

endmodule

// File: tb/tb_mac_share_arbiter.sv
module tb_mac_share_arbiter;

  localparam int N     = 4;
  localparam int DEPTH = 8;
  localparam int LAT   = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [16*N-1:0]  req_a, req_b, req_c, req_d, req_e;
  logic             mac_in_valid;
  logic             mac_in_ready;
  logic [15:0]      mac_a, mac_b, mac_c, mac_d, mac_e;
  logic             mac_out_valid;
  logic             mac_out_ready;
  logic [31:0]      mac_y;
  logic [N-1:0]     rsp_valid;
  logic [N-1:0]     rsp_ready;
  logic [31:0]      rsp_y;
  logic [3:0]       outstanding;
  logic             proto_err;

  logic             m_ov = 1'b0;
  logic [31:0]      m_y = '0;
  logic             force_ov = 1'b0;

  assign mac_out_valid = m_ov | force_ov;
  assign mac_y         = m_ov ? m_y : 32'hDEAD_BEEF;

  always #5 clk = ~clk;

  mac_share_arbiter #(.N_REQ(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d), .req_e(req_e),
    .mac_in_valid(mac_in_valid), .mac_in_ready(mac_in_ready),
    .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_d(mac_d), .mac_e(mac_e),
    .mac_out_valid(mac_out_valid), .mac_out_ready(mac_out_ready), .mac_y(mac_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
    .outstanding(outstanding), .proto_err(proto_err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] calc(input logic [15:0] a, input logic [15:0] b,
                                       input logic [15:0] c, input logic [15:0] d,
                                       input logic [15:0] e);
    longint r;
    r = longint'($signed(a)) * longint'($signed(b)) +
        longint'($signed(c)) * longint'($signed(d)) + longint'($signed(e));
    return r[31:0];
  endfunction

  // Behavioural MAC: fixed latency, unlimited internal buffering, in order.
  typedef struct { logic [31:0] y; int t; } mac_ent_t;
  mac_ent_t mq[$];
  int       cyc = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_ov <= 1'b0;
      m_y  <= '0;
    end else begin
      mac_ent_t ent;
      cyc++;
      if (m_ov && mac_out_ready) mq.pop_front();
      if (mac_in_valid && mac_in_ready) begin
        ent.y = calc(mac_a, mac_b, mac_c, mac_d, mac_e);
        ent.t = cyc + LAT - 1;
        mq.push_back(ent);
      end
      if (mq.size() > 0 && mq[0].t <= cyc) begin
        m_ov <= 1'b1;
        m_y  <= mq[0].y;
      end else begin
        m_ov <= 1'b0;
        m_y  <= '0;
      end
    end
  end

  // Reference model: pending operations as a queue of {owner, expected result}.
  typedef struct { int tag; logic [31:0] y; } exp_t;
  exp_t m_q[$];
  int   m_rr;
  bit   m_busy;
  bit   m_perr;
  int   grants[$];

  task automatic model_reset();
    m_q.delete();
    m_rr   = N - 1;
    m_busy = 1'b0;
    m_perr = 1'b0;
  endtask

  // Called right after inputs are driven at the falling edge; checks the
  // outputs for this cycle, then advances the model across the next rise.
  task automatic check_cycle();
    int           w;
    int           head;
    int           idx;
    bit           can;
    bit           acc;
    logic [N-1:0] e_rr;
    logic [N-1:0] e_rv;
    logic         e_mor;
    exp_t         ent;
    #1;
    w = -1;
    for (int k = 1; k <= N; k++) begin
      idx = (m_rr + k) % N;
      if (w < 0 && req_valid[idx]) w = idx;
    end
    can  = (!m_busy || mac_in_ready) && (m_q.size() < DEPTH);
    e_rr = '0;
    if (w >= 0 && can) e_rr[w] = 1'b1;
    chk("req_ready", req_ready, e_rr);
    chk("mac_in_valid", mac_in_valid, m_busy);
    chk("outstanding", outstanding, m_q.size());
    chk("proto_err", proto_err, m_perr);

    e_rv  = '0;
    e_mor = 1'b0;
    head  = -1;
    if (m_q.size() > 0) begin
      head  = m_q[0].tag;
      e_mor = rsp_ready[head];
      if (mac_out_valid) e_rv[head] = 1'b1;
    end
    chk("rsp_valid", rsp_valid, e_rv);
    chk("mac_out_ready", mac_out_ready, e_mor);
    if (e_rv != '0) chk("rsp_y", rsp_y, m_q[0].y);

    acc = (w >= 0) && can;
    if (mac_out_valid && m_q.size() == 0) m_perr = 1'b1;
    if (mac_out_valid && m_q.size() > 0 && rsp_ready[head]) void'(m_q.pop_front());
    if (acc) begin
      ent.tag = w;
      ent.y   = calc(req_a[16*w +: 16], req_b[16*w +: 16], req_c[16*w +: 16],
                     req_d[16*w +: 16], req_e[16*w +: 16]);
      m_q.push_back(ent);
      m_rr = w;
      grants.push_back(w);
    end
    if (acc) m_busy = 1'b1;
    else if (mac_in_ready) m_busy = 1'b0;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] rr, input logic mir);
    req_valid    = v;
    rsp_ready    = rr;
    mac_in_ready = mir;
  endtask

  task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d, input logic [15:0] e);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
    req_c[16*i +: 16] = c;
    req_d[16*i +: 16] = d;
    req_e[16*i +: 16] = e;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++)
      set_ops(i, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (m_q.size() != 0 && n < 200) begin
      @(negedge clk);
      drive('0, '1, 1'b1);
      check_cycle();
      n++;
    end
    @(negedge clk);
    drive('0, '1, 1'b1);
    check_cycle();
    chk(name, outstanding, 0);
  endtask

  typedef struct {
    int          req;
    logic [15:0] a, b, c, d, e;
    logic [31:0] exp_y;
    logic [N-1:0] exp_rv;
  } vec_t;
  vec_t tbl[6];

  task automatic run_vec(input vec_t v);
    logic [N-1:0] onehot;
    logic [N-1:0] got_rv;
    logic [31:0]  got_y;
    int           n;
    wait_drain("vec_drain");
    onehot         = '0;
    onehot[v.req]  = 1'b1;
    @(negedge clk);
    drive(onehot, '1, 1'b1);
    rand_ops();
    set_ops(v.req, v.a, v.b, v.c, v.d, v.e);
    check_cycle();
    chk("vec_accept", req_ready, onehot);
    got_rv = '0;
    got_y  = '0;
    n      = 0;
    while (got_rv == '0 && n < 30) begin
      @(negedge clk);
      drive('0, '1, 1'b1);
      rand_ops();
      check_cycle();
      if (rsp_valid != '0) begin
        got_rv = rsp_valid;
        got_y  = rsp_y;
      end
      n++;
    end
    chk("vec_rsp_valid", got_rv, v.exp_rv);
    chk("vec_rsp_y", got_y, v.exp_y);
    @(negedge clk);
    drive('0, '1, 1'b1);
    check_cycle();
    chk("vec_outstanding", outstanding, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit resumed;

    tbl[0] = '{2, 16'd3,    16'd4,    16'd5,    16'd6,    16'd7,    32'd49,         4'b0100};
    tbl[1] = '{0, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 32'd2147450880, 4'b0001};
    tbl[2] = '{1, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 32'd2147385345, 4'b0010};
    tbl[3] = '{3, 16'hFFFB, 16'd7,    16'd100,  16'hFF38, 16'd1000, 32'hFFFF_B5A5,  4'b1000};
    tbl[4] = '{0, 16'h7FFF, 16'h8000, 16'h8000, 16'h7FFF, 16'h0000, 32'h8001_0000,  4'b0001};
    tbl[5] = '{3, 16'd1,    16'd2,    16'd3,    16'd4,    16'd5,    32'd19,         4'b1000};

    drive('0, '0, 1'b0);
    req_a = '0; req_b = '0; req_c = '0; req_d = '0; req_e = '0;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_mac_in_valid", mac_in_valid, 0);
    chk("reset_outstanding", outstanding, 0);
    chk("reset_proto_err", proto_err, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_mac_out_ready", mac_out_ready, 0);
    chk("reset_mac_a", mac_a, 0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    // Round robin from reset: all requesters continuously valid.
    grants.delete();
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      drive('1, '1, 1'b1);
      rand_ops();
      check_cycle();
    end
    for (int k = 0; k < 8; k++)
      chk("rr_order", (grants.size() > k) ? grants[k] : -1, k % N);

    for (int t = 0; t < 5; t++) run_vec(tbl[t]);

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      logic [N-1:0] rr;
      for (int i = 0; i < N; i++) rr[i] = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      drive(N'($urandom), rr, ($urandom_range(0, 4) != 0));
      rand_ops();
      check_cycle();
    end

    // Backpressure: requester 1 fills the FIFO while its responses are held.
    wait_drain("bp_drain");
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      drive(4'b0010, 4'b1101, 1'b1);
      rand_ops();
      check_cycle();
    end
    chk("bp_full", outstanding, DEPTH);
    @(negedge clk);
    drive('1, 4'b1101, 1'b1);
    rand_ops();
    check_cycle();
    chk("bp_blocked", req_ready, 0);
    @(negedge clk);
    drive('1, '1, 1'b1);
    rand_ops();
    check_cycle();
    chk("bp_pop_when_full", mac_out_ready, 1);
    chk("bp_full_blocks_accept", req_ready, 0);
    resumed = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      drive('1, '1, 1'b1);
      rand_ops();
      check_cycle();
      if (req_ready != '0) resumed = 1'b1;
    end
    chk("bp_resume", resumed, 1);
    wait_drain("bp_final_drain");

    // Protocol error: MAC result with nothing pending.
    @(negedge clk);
    drive('0, '1, 1'b1);
    force_ov = 1'b1;
    check_cycle();
    chk("perr_no_ack", mac_out_ready, 0);
    @(negedge clk);
    force_ov = 1'b0;
    check_cycle();
    chk("perr_set", proto_err, 1);
    repeat (5) begin
      @(negedge clk);
      check_cycle();
    end
    chk("perr_sticky", proto_err, 1);

    // Reset with three operations in flight.
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      drive('1, '0, 1'b1);
      rand_ops();
      check_cycle();
    end
    @(negedge clk);
    drive('0, '0, 1'b1);
    check_cycle();
    chk("pre_rst_outstanding", outstanding, 3);
    #2 rst = 1'b0;
    #1;
    chk("rst_outstanding", outstanding, 0);
    chk("rst_mac_in_valid", mac_in_valid, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_mac_out_ready", mac_out_ready, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_mac_a", mac_a, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      drive('0, '1, 1'b1);
      check_cycle();
    end
    run_vec(tbl[5]);
    wait_drain("end_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
